product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream stage of the array multiplier. It consumes the multiplier's valid-qualified product stream and sums each group of ACC_LEN consecutive products into a widened, overflow-free result. Completed sums go into a 2-entry output buffer with a valid/ready handshake. The multiplier has no backpressure, so results that arrive while the buffer is full are dropped and flagged.

## Interface
Parameters:
- DATAWIDTH, 4, multiplier operand width; products are 2*DATAWIDTH bits.
- ACC_LEN, 4, products per group; must be ≥2.
- ACCWIDTH (localparam), 2*DATAWIDTH + $clog2(ACC_LEN), result width.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- i_valid  input  1  product valid, driven by the multiplier's o_valid.
- i_product  input  2*DATAWIDTH  unsigned product, driven by the multiplier's Z_final.
- i_clear  input  1  discards the partial group.
- i_ready  input  1  downstream can accept o_sum.
- o_valid  output  1  output buffer non-empty.
- o_sum  output  ACCWIDTH  head-of-buffer sum.
- o_overflow  output  1  sticky flag: a completed sum was dropped.

## Operation
- All arithmetic is unsigned. ACCWIDTH covers ACC_LEN*(2^DATAWIDTH-1)^2, so the sum cannot wrap.
- FSM with states IDLE and ACCUM. Counter cnt runs 0..ACC_LEN-1.
  - IDLE + i_valid: acc ← i_product, cnt ← 1, go to ACCUM.
  - ACCUM + i_valid, cnt < ACC_LEN-1: acc ← acc + i_product, cnt++.
  - ACCUM + i_valid, cnt = ACC_LEN-1: push acc + i_product, cnt ← 0, go to IDLE.
  - Cycles with i_valid low leave acc, cnt and state unchanged. Gaps inside a group are allowed.
- i_clear has priority over accumulation. It discards acc and sets cnt ← 0.
  - i_clear with i_valid low: go to IDLE.
  - i_clear with i_valid high in the same cycle: that product starts a new group (acc ← i_product, cnt ← 1, ACCUM).
  - i_clear never affects the output buffer.
- Output buffer: 2-entry FIFO.
  - Pop on o_valid && i_ready.
  - Push to a full buffer in the same cycle as a pop is accepted.
  - Push to a full buffer without a pop drops the sum and sets o_overflow. o_overflow clears only on reset.
- o_sum is don't-care when o_valid=0, but is driven from the FIFO head register (zero after reset).

## Timing
- Reset (rst=0 at a clock edge): state IDLE, cnt=0, acc=0, FIFO empty, o_valid=0, o_sum=0, o_overflow=0.
- Reset mid-group or with buffered results discards everything.
- Latency: last product of a group accepted at edge t → o_valid=1 with that sum after edge t+1, provided the buffer had space.
- Throughput: one product per cycle. A new group may start the cycle after completion with no bubble.
- o_valid/o_sum stay stable until popped (AXI-style). i_ready may be high without o_valid.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package accum_pkg holds:
  - typedef enum logic {IDLE, ACCUM} acc_state_t;
  - FIFO_DEPTH = 2.
- Sub-module sum_fifo: parameterised width, depth-2 synchronous FIFO.
  - Ports: push, pop, data in/out, full, empty.
  - Supports push on full when a pop is accepted in the same cycle.
- Top-level RTL holds the FSM, counter, adder and overflow flag.

## Test plan
Defaults DATAWIDTH=4, ACC_LEN=4 unless stated.
1. Products 3,5,7,9 on consecutive cycles, i_ready=1 → o_sum=24, o_valid high for exactly one cycle, one cycle after the product 9 is accepted.
2. Four products of 225 → o_sum=900 (ACCWIDTH=10, no wrap). Repeat with i_valid gaps of 2 cycles between products → same result.
3. i_ready=0, three full groups summing to 10, 20, 30 → buffer holds 10 then 20, third sum dropped, o_overflow=1. Then raise i_ready → pops 10 then 20, o_overflow stays 1.
4. Buffer full, i_ready pulsed high in the same cycle a group of 1,1,1,1 completes → no drop, o_overflow=0, pop order old-head then 4.
5. Products 8,8, then i_clear with i_valid=1 and product 2, followed by 2,2,2 → o_sum=8.
6. rst=0 asserted after two products with one sum buffered → all outputs 0 next cycle. A fresh group 1,2,3,4 → o_sum=10.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and sizing for the product accumulator block.
package accum_pkg;

  // Group accumulator states: waiting for the first product, or mid-group.
  typedef enum logic {IDLE, ACCUM} acc_state_t;

  // Completed sums are buffered two deep ahead of the downstream consumer.
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/product_accumulator_sum_fifo.sv
// Two-entry synchronous FIFO holding completed group sums.
// A push into a full FIFO is accepted when a pop happens in the same cycle;
// otherwise the push is ignored and the caller is expected to flag it.
module sum_fifo
  import accum_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == CNTW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Head comes straight from storage so the output is a register, not a
  // function of this cycle's inputs.
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // When full, wr_ptr equals rd_ptr: the slot being written is the one
    // being popped this cycle, so it becomes the new tail.
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of ACC_LEN consecutive multiplier products into a widened
// result and hands completed sums to a 2-entry valid/ready buffer.
// The upstream multiplier cannot be stalled, so a sum that finds the buffer
// full (with no pop that cycle) is dropped and a sticky overflow is raised.
module product_accumulator
  import accum_pkg::*;
#(
  parameter int DATAWIDTH = 4,
  parameter int ACC_LEN   = 4,
  localparam int ACCWIDTH = 2 * DATAWIDTH + $clog2(ACC_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [2*DATAWIDTH-1:0] i_product,
  input  logic                   i_clear,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [ACCWIDTH-1:0]    o_sum,
  output logic                   o_overflow
);

  localparam int CNTW = $clog2(ACC_LEN);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ACC_LEN - 1);

  acc_state_t          state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic                push_q, push_d;
  logic [ACCWIDTH-1:0] push_sum_q, push_sum_d;
  logic                ovf_q, ovf_d;

  logic [ACCWIDTH-1:0] prod_ext;
  logic [ACCWIDTH-1:0] sum_next;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  // ACCWIDTH holds ACC_LEN full-scale products, so this add never wraps.
  assign prod_ext = ACCWIDTH'(i_product);
  assign sum_next = acc_q + prod_ext;

  assign o_valid    = !fifo_empty;
  assign fifo_pop   = o_valid && i_ready;
  assign o_overflow = ovf_q;

  // Group FSM, counter and adder; clear outranks accumulation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    push_d     = 1'b0;
    push_sum_d = push_sum_q;
    if (i_clear) begin
      // A product arriving with the clear opens the next group.
      if (i_valid) begin
        acc_d   = prod_ext;
        cnt_d   = CNTW'(1);
        state_d = ACCUM;
      end else begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end else if (i_valid) begin
      case (state_q)
        IDLE: begin
          acc_d   = prod_ext;
          cnt_d   = CNTW'(1);
          state_d = ACCUM;
        end
        ACCUM: begin
          if (cnt_q == CNT_LAST) begin
            push_d     = 1'b1;
            push_sum_d = sum_next;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            acc_d = sum_next;
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sticky overflow: a registered push meets a full buffer with no pop.
  always_comb begin
    ovf_d = ovf_q | (push_q & fifo_full & ~fifo_pop);
  end

  // Control and datapath registers; the completed sum is staged one cycle
  // before entering the buffer so o_valid rises the cycle after completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      push_q     <= 1'b0;
      push_sum_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      push_q     <= push_d;
      push_sum_q <= push_sum_d;
      ovf_q      <= ovf_d;
    end
  end

  sum_fifo #(
    .WIDTH (ACCWIDTH)
  ) u_sum_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (fifo_pop),
    .din   (push_sum_q),
    .dout  (o_sum),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (DATAWIDTH=4, ACC_LEN=4).
module tb_product_accumulator;

  localparam int DATAWIDTH = 4;
  localparam int ACC_LEN   = 4;
  localparam int PW        = 2 * DATAWIDTH;
  localparam int ACCWIDTH  = PW + $clog2(ACC_LEN);

  logic                clk = 1'b0;
  logic                rst;
  logic                i_valid;
  logic [PW-1:0]       i_product;
  logic                i_clear;
  logic                i_ready;
  logic                o_valid;
  logic [ACCWIDTH-1:0] o_sum;
  logic                o_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  // Reference model state
  bit m_accum;
  int m_acc;
  int m_cnt;
  bit m_pend;
  int m_pend_val;
  int m_occ;
  bit m_ovf;
  bit m_pop;

  always #5 clk = ~clk;

  product_accumulator #(
    .DATAWIDTH (DATAWIDTH),
    .ACC_LEN   (ACC_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_product  (i_product),
    .i_clear    (i_clear),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_sum      (o_sum),
    .o_overflow (o_overflow)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: group sums, one-cycle staging, 2-deep buffer.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_accum = 0; m_acc = 0; m_cnt = 0; m_pend = 0;
        m_occ = 0; m_ovf = 0;
        exp_q.delete();
      end else begin
        m_pop = (m_occ > 0) && i_ready;
        if (m_pend) begin
          if (m_occ == 2 && !m_pop) m_ovf = 1;
          else begin
            exp_q.push_back(m_pend_val);
            m_occ++;
          end
        end
        if (m_pop) m_occ--;
        m_pend = 0;
        if (i_clear) begin
          if (i_valid) begin m_acc = int'(i_product); m_cnt = 1; m_accum = 1; end
          else begin m_acc = 0; m_cnt = 0; m_accum = 0; end
        end else if (i_valid) begin
          if (!m_accum) begin
            m_acc = int'(i_product); m_cnt = 1; m_accum = 1;
          end else if (m_cnt == ACC_LEN - 1) begin
            m_pend = 1; m_pend_val = m_acc + int'(i_product);
            m_acc = 0; m_cnt = 0; m_accum = 0;
          end else begin
            m_acc = m_acc + int'(i_product); m_cnt++;
          end
        end
      end
    end
  end

  // Monitor: handshake, flag and popped-sum checks away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check_eq("o_valid", int'(o_valid), int'(m_occ > 0));
        check_eq("o_overflow", int'(o_overflow), int'(m_ovf));
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) check_eq("sb_underflow", exp_q.size(), 1);
          else check_eq("o_sum", int'(o_sum), exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic v, input int p, input logic clr);
    @(posedge clk);
    #1;
    i_valid   = v;
    i_product = p[PW-1:0];
    i_clear   = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0);
  endtask

  task automatic group(input int a, input int b, input int c, input int d);
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    step(1'b1, c, 1'b0);
    step(1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0; i_clear = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_product = '0; i_clear = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rst_o_valid", int'(o_valid), 0);
    check_eq("rst_o_sum", int'(o_sum), 0);
    check_eq("rst_o_overflow", int'(o_overflow), 0);

    // 1: 3+5+7+9, valid exactly one cycle, one cycle after last product
    i_ready = 1'b1;
    group(3, 5, 7, 9);
    step(1'b0, 0, 1'b0);
    @(negedge clk);
    check_eq("t1_latency_low", int'(o_valid), 0);
    @(negedge clk);
    check_eq("t1_valid", int'(o_valid), 1);
    check_eq("t1_sum", int'(o_sum), 24);
    @(negedge clk);
    check_eq("t1_one_cycle", int'(o_valid), 0);

    // 2: full-scale products, back-to-back then with 2-cycle gaps
    group(225, 225, 225, 225);
    idle(3);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 225, 1'b0);
      idle(2);
    end
    idle(3);

    // 3: three groups into a stalled buffer, third dropped
    i_ready = 1'b0;
    group(1, 2, 3, 4);
    group(5, 5, 5, 5);
    group(6, 7, 8, 9);
    idle(3);
    @(negedge clk);
    check_eq("t3_overflow", int'(o_overflow), 1);
    check_eq("t3_head", int'(o_sum), 10);
    step(1'b0, 0, 1'b0);
    i_ready = 1'b1;
    idle(4);
    @(negedge clk);
    check_eq("t3_drained", int'(o_valid), 0);
    check_eq("t3_overflow_sticky", int'(o_overflow), 1);

    // 4: push into full buffer while a pop is accepted
    do_reset();
    i_ready = 1'b0;
    group(1, 2, 3, 4);
    group(5, 5, 5, 5);
    group(1, 1, 1, 1);
    step(1'b0, 0, 1'b0);
    i_ready = 1'b1;
    step(1'b0, 0, 1'b0);
    i_ready = 1'b0;
    idle(2);
    @(negedge clk);
    check_eq("t4_no_drop", int'(o_overflow), 0);
    check_eq("t4_head", int'(o_sum), 20);
    step(1'b0, 0, 1'b0);
    i_ready = 1'b1;
    idle(4);

    // 5: clear with a coincident product restarts the group
    step(1'b1, 8, 1'b0);
    step(1'b1, 8, 1'b0);
    step(1'b1, 2, 1'b1);
    step(1'b1, 2, 1'b0);
    step(1'b1, 2, 1'b0);
    step(1'b1, 2, 1'b0);
    idle(4);

    // 5b: clear without a product drops the partial group
    step(1'b1, 50, 1'b0);
    step(1'b0, 0, 1'b1);
    group(4, 4, 4, 4);
    idle(4);

    // 6: reset with a partial group and a buffered sum
    i_ready = 1'b0;
    group(1, 1, 1, 1);
    idle(2);
    step(1'b1, 2, 1'b0);
    step(1'b1, 2, 1'b0);
    step(1'b0, 0, 1'b0);
    rst = 1'b0;
    step(1'b0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_valid", int'(o_valid), 0);
    check_eq("t6_rst_sum", int'(o_sum), 0);
    check_eq("t6_rst_overflow", int'(o_overflow), 0);
    step(1'b0, 0, 1'b0);
    i_ready = 1'b1;
    group(1, 2, 3, 4);
    step(1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_fresh_sum", int'(o_sum), 10);

    // Drain with a bounded wait
    for (int w = 0; w < 40 && (exp_q.size() > 0 || m_occ > 0 || m_pend); w++) begin
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
